// File: rtl/adder_mul_seq.sv
// Multi-cycle unsigned multiplier (low WIDTH bits of the product) that iterates
// shift-and-add through an external shared adder, finishing early once no multiplier bits remain.
module adder_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_sum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on accept
    // RUN   | one multiplier bit consumed per cycle until none remain
    // DONE  | one-cycle completion pulse, result valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;

    assign adder_a = acc;
    assign adder_b = mc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        acc   <= '0;
                        mc    <= op_a;
                        mp    <= op_b;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mp == '0) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (mp[0]) acc <= adder_sum;
                        // bits shifted past the MSB belong to the discarded upper half
                        mc <= mc << 1;
                        mp <= mp >> 1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
